// File: rtl/uart_txrx.sv
// 8N1 UART transceiver, independent TX and RX sharing one baud count.
// Define UART_RX_SYNC_EN to pass rx_serial_input through a 2-flop synchronizer.
module uart_txrx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       tx_data_valid,
  input  logic [7:0] in,
  output logic       tx_active,
  output logic       tx_serial_data,
  output logic       tx_done,
  input  logic       rx_serial_input,
  output logic       rx_data_valid,
  output logic [7:0] rx_output
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, CLEANUP
  } state_t;

  state_t          tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]      tx_idx, tx_idx_n;
  logic [7:0]      tx_data, tx_data_n;
  logic            tx_active_n, tx_done_n;

  state_t          rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_idx, rx_idx_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic [7:0]      rx_output_n;
  logic            rx_valid_n;
  logic            rx_line;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], rx_serial_input};
  end
  assign rx_line = rx_sync[1];
`else
  assign rx_line = rx_serial_input;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_state  <= IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_data   <= '0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_idx    <= tx_idx_n;
      tx_data   <= tx_data_n;
      tx_active <= tx_active_n;
      tx_done   <= tx_done_n;
    end
  end

  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt;
    tx_idx_n    = tx_idx;
    tx_data_n   = tx_data;
    tx_active_n = tx_active;
    tx_done_n   = 1'b0;
    unique case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        tx_idx_n = '0;
        if (tx_data_valid) begin
          tx_data_n   = in;
          tx_active_n = 1'b1;
          tx_state_n  = START;
        end
      end
      START: begin
        if (tx_cnt < LAST) tx_cnt_n = tx_cnt + 1'b1;
        else begin
          tx_cnt_n   = '0;
          tx_state_n = DATA;
        end
      end
      DATA: begin
        if (tx_cnt < LAST) tx_cnt_n = tx_cnt + 1'b1;
        else begin
          tx_cnt_n = '0;
          tx_idx_n = tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_state_n = STOP;
        end
      end
      STOP: begin
        if (tx_cnt < LAST) tx_cnt_n = tx_cnt + 1'b1;
        else begin
          tx_cnt_n    = '0;
          tx_done_n   = 1'b1;
          tx_active_n = 1'b0;
          tx_state_n  = CLEANUP;
        end
      end
      CLEANUP: tx_state_n = IDLE;
      default: tx_state_n = IDLE;
    endcase
  end

  // Line level is decoded from registered state, so it tracks state exactly.
  always_comb begin
    tx_serial_data = 1'b1;
    if (tx_state == START)     tx_serial_data = 1'b0;
    else if (tx_state == DATA) tx_serial_data = tx_data[tx_idx];
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_state      <= IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_output     <= '0;
      rx_data_valid <= 1'b0;
    end else begin
      rx_state      <= rx_state_n;
      rx_cnt        <= rx_cnt_n;
      rx_idx        <= rx_idx_n;
      rx_shift      <= rx_shift_n;
      rx_output     <= rx_output_n;
      rx_data_valid <= rx_valid_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_idx_n    = rx_idx;
    rx_shift_n  = rx_shift;
    rx_output_n = rx_output;
    rx_valid_n  = 1'b0;
    unique case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (!rx_line) rx_state_n = START;
      end
      START: begin
        if (rx_cnt == MID) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_line ? IDLE : DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      DATA: begin
        if (rx_cnt < LAST) rx_cnt_n = rx_cnt + 1'b1;
        else begin
          rx_cnt_n           = '0;
          rx_shift_n[rx_idx] = rx_line;
          rx_idx_n           = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_state_n = STOP;
        end
      end
      STOP: begin
        if (rx_cnt < LAST) rx_cnt_n = rx_cnt + 1'b1;
        else begin
          rx_cnt_n   = '0;
          rx_state_n = CLEANUP;
          if (rx_line) begin
            rx_output_n = rx_shift;
            rx_valid_n  = 1'b1;
          end
        end
      end
      CLEANUP: rx_state_n = IDLE;
      default: rx_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Scoreboard bench for uart_txrx: loopback and directly driven RX frames.
// Expected RX bytes are queued by stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_uart_txrx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_data_valid = 1'b0;
  logic [7:0] in = '0;
  logic       tx_active, tx_serial_data, tx_done;
  logic       rx_drive = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_line;
  logic       rx_data_valid;
  logic [7:0] rx_output;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int done_cnt = 0;
  logic [7:0] sb[$];

  assign rx_line = loop_en ? tx_serial_data : rx_drive;

  always #50 clk = ~clk;

  uart_txrx #(.CLKS_PER_BIT(87)) dut (
    .i_Clock(clk),
    .i_Rst_n(rst_n),
    .tx_data_valid(tx_data_valid),
    .in(in),
    .tx_active(tx_active),
    .tx_serial_data(tx_serial_data),
    .tx_done(tx_done),
    .rx_serial_input(rx_line),
    .rx_data_valid(rx_data_valid),
    .rx_output(rx_output)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops scoreboard on every rx pulse and polices pulse widths.
  logic prev_rxv = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n && rx_data_valid) begin
      rx_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_output);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (rx_output !== e) begin
          errors++;
          $display("FAIL rx_byte: got %0h expected %0h", rx_output, e);
        end
      end
    end
    if (rst_n && tx_done) done_cnt++;
    if (prev_rxv && rx_data_valid) begin
      errors++;
      $display("FAIL rx_pulse_width: got 2 cycles expected 1");
    end
    if (prev_done && tx_done) begin
      errors++;
      $display("FAIL tx_done_width: got 2 cycles expected 1");
    end
    prev_rxv  = rx_data_valid;
    prev_done = tx_done;
  end

  task automatic send_tx(input logic [7:0] b);
    @(negedge clk);
    in = b;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 3000 && !tx_done) begin
      @(negedge clk);
      n++;
    end
    if (!tx_done) begin
      errors++;
      checks++;
      $display("FAIL tx_done_timeout: got none expected pulse");
    end
  endtask

  task automatic wait_sb();
    int n = 0;
    while (n < 3000 && sb.size() != 0) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_lvl,
                          input int start_ns, input int bit_ns);
    rx_drive = 1'b0;
    #(start_ns);
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      #(bit_ns);
    end
    rx_drive = stop_lvl;
    #(bit_ns);
    rx_drive = 1'b1;
  endtask

  initial begin
    int n, base, d0;
    logic [7:0] held;
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", tx_serial_data, 1);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_rx_valid", rx_data_valid, 0);
    chk("rst_rx_output", rx_output, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback AB and frame length
    loop_en = 1'b1;
    sb.push_back(8'hAB);
    @(negedge clk);
    in = 8'hAB;
    tx_data_valid = 1'b1;
    n = 0;
    @(negedge clk);
    tx_data_valid = 1'b0;
    n = 1;
    chk("tx_active_start", tx_active, 1);
    chk("tx_line_start", tx_serial_data, 0);
    while (n < 3000 && !tx_done) begin
      @(negedge clk);
      n++;
    end
    chk("tx_frame_len_ok", (n >= 869 && n <= 873), 1);
    chk("tx_active_after", tx_active, 0);
    wait_sb();
    chk("rx_out_ab", rx_output, 8'hAB);
    repeat (20) @(negedge clk);

    // Direct frame at slightly fast baud
    loop_en = 1'b0;
    sb.push_back(8'h3F);
    base = rx_cnt;
    drive_rx(8'h3F, 1'b1, 9600, 8600);
    repeat (100) @(negedge clk);
    wait_sb();
    chk("rx_3f_pulses", rx_cnt - base, 1);
    chk("rx_out_3f", rx_output, 8'h3F);

    // Short glitch rejected
    base = rx_cnt;
    held = rx_output;
    @(negedge clk);
    rx_drive = 1'b0;
    repeat (20) @(negedge clk);
    rx_drive = 1'b1;
    repeat (1500) @(negedge clk);
    chk("glitch_no_pulse", rx_cnt - base, 0);
    chk("glitch_out_held", rx_output, held);

    // Framing error then good frame
    base = rx_cnt;
    drive_rx(8'h55, 1'b0, 8700, 8700);
    repeat (300) @(negedge clk);
    chk("frame_err_no_pulse", rx_cnt - base, 0);
    chk("frame_err_out_held", rx_output, 8'h3F);
    sb.push_back(8'hC3);
    drive_rx(8'hC3, 1'b1, 8700, 8700);
    repeat (100) @(negedge clk);
    wait_sb();
    chk("rx_out_c3", rx_output, 8'hC3);

    // Mid-frame request ignored; back-to-back accept from IDLE
    loop_en = 1'b1;
    d0 = done_cnt;
    sb.push_back(8'hE7);
    send_tx(8'hE7);
    repeat (400) @(negedge clk);
    send_tx(8'h12);
    in = 8'hFF;
    wait_done(n);
    chk("cleanup_active_low", tx_active, 0);
    @(negedge clk);
    chk("idle_active_low", tx_active, 0);
    sb.push_back(8'h5A);
    in = 8'h5A;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    chk("accept_active_high", tx_active, 1);
    wait_done(n);
    repeat (1000) @(negedge clk);
    wait_sb();
    chk("tx_done_count", done_cnt - d0, 2);

    // Reset mid-frame
    base = rx_cnt;
    send_tx(8'h77);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_line", tx_serial_data, 1);
    chk("rst_mid_active", tx_active, 0);
    chk("rst_mid_rx_out", rx_output, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    chk("rst_no_rx", rx_cnt - base, 0);
    sb.push_back(8'hA5);
    send_tx(8'hA5);
    wait_done(n);
    repeat (10) @(negedge clk);
    wait_sb();
    chk("rx_out_a5", rx_output, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
